// File: rtl/operand_fetch.sv
// Operand read sequencer: walks C[i][j] of a 4x4 product, fetching A/B pairs from the register file.
// Optional build macro OPERAND_FETCH_TRANSPOSE_B_EN selects column-major storage of B.
module operand_fetch #(
  parameter logic [4:0] A_BASE = 5'd0,
  parameter logic [4:0] B_BASE = 5'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] rf_addr_1,
  output logic [4:0] rf_addr_2,
  output logic [4:0] rf_addr_3,
  output logic [4:0] rf_addr_4,
  input  logic [7:0] rf_data_1,
  input  logic [7:0] rf_data_2,
  input  logic [7:0] rf_data_3,
  input  logic [7:0] rf_data_4,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [7:0] op_a0,
  output logic [7:0] op_a1,
  output logic [7:0] op_b0,
  output logic [7:0] op_b1,
  output logic [1:0] op_row,
  output logic [1:0] op_col,
  output logic       op_half,
  output logic       op_last
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t     state, state_next;
  logic [1:0] cnt_i, cnt_j, cnt_i_next, cnt_j_next;
  logic       cnt_h, cnt_h_next;
  logic       busy_next, done_next, valid_next, last_next, half_next;
  logic [7:0] a0_next, a1_next, b0_next, b1_next;
  logic [1:0] row_next, col_next;
  logic       load, cnt_last;

  // A load is allowed whenever the output register is empty or being drained this edge.
  assign load     = (state == FETCH) && (!op_valid || op_ready);
  assign cnt_last = (cnt_i == 2'd3) && (cnt_j == 2'd3) && cnt_h;

  assign rf_addr_1 = A_BASE + {1'b0, cnt_i, 2'b00} + {3'b000, cnt_h, 1'b0};
  assign rf_addr_2 = A_BASE + {1'b0, cnt_i, 2'b00} + {3'b000, cnt_h, 1'b1};
`ifdef OPERAND_FETCH_TRANSPOSE_B_EN
  assign rf_addr_3 = B_BASE + {1'b0, cnt_j, cnt_h, 1'b0};
  assign rf_addr_4 = B_BASE + {1'b0, cnt_j, cnt_h, 1'b1};
`else
  assign rf_addr_3 = B_BASE + {1'b0, cnt_h, 3'b000} + {3'b000, cnt_j};
  assign rf_addr_4 = B_BASE + {1'b0, cnt_h, 3'b100} + {3'b000, cnt_j};
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_next = state;
    cnt_i_next = cnt_i;
    cnt_j_next = cnt_j;
    cnt_h_next = cnt_h;
    busy_next  = busy;
    done_next  = 1'b0;
    valid_next = op_valid;
    last_next  = op_last;
    half_next  = op_half;
    row_next   = op_row;
    col_next   = op_col;
    a0_next    = op_a0;
    a1_next    = op_a1;
    b0_next    = op_b0;
    b1_next    = op_b1;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          busy_next  = 1'b1;
          cnt_i_next = 2'd0;
          cnt_j_next = 2'd0;
          cnt_h_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      FETCH: begin
        if (load) begin
          valid_next = 1'b1;
          a0_next    = rf_data_1;
          a1_next    = rf_data_2;
          b0_next    = rf_data_3;
          b1_next    = rf_data_4;
          row_next   = cnt_i;
          col_next   = cnt_j;
          half_next  = cnt_h;
          last_next  = cnt_last;
          // h is the fastest digit, then j, then i; beat 31 wraps the counters to zero.
          {cnt_i_next, cnt_j_next, cnt_h_next} = {cnt_i, cnt_j, cnt_h} + 5'd1;
          state_next = cnt_last ? DRAIN : FETCH;
        end else begin
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (op_valid && op_ready) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt_i    <= 2'd0;
      cnt_j    <= 2'd0;
      cnt_h    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_valid <= 1'b0;
      op_last  <= 1'b0;
      op_half  <= 1'b0;
      op_row   <= 2'd0;
      op_col   <= 2'd0;
      op_a0    <= 8'd0;
      op_a1    <= 8'd0;
      op_b0    <= 8'd0;
      op_b1    <= 8'd0;
    end else begin
      state    <= state_next;
      cnt_i    <= cnt_i_next;
      cnt_j    <= cnt_j_next;
      cnt_h    <= cnt_h_next;
      busy     <= busy_next;
      done     <= done_next;
      op_valid <= valid_next;
      op_last  <= last_next;
      op_half  <= half_next;
      op_row   <= row_next;
      op_col   <= col_next;
      op_a0    <= a0_next;
      op_a1    <= a1_next;
      op_b0    <= b0_next;
      op_b1    <= b1_next;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: two instances (default bases and A_BASE=20/B_BASE=0) checked against
// an index-arithmetic model of the beat sequence over a shared register-file array.
module tb_operand_fetch;

  typedef logic [3:0][4:0] addr4_t;
  typedef logic [3:0][7:0] data4_t;

  localparam int A1 = 0;
  localparam int B1 = 16;
  localparam int A2 = 20;
  localparam int B2 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, op_ready, ident;
  logic [7:0] rf [32];
  int vectors = 0;
  int fails = 0;

  logic busy1, done1, valid1, last1, half1, busy2, done2, valid2, last2, half2;
  logic [1:0] row1, col1, row2, col2;
  addr4_t ad1, ad2;
  data4_t rd1, rd2, op1, op2;

  // Combinational register-file reads for both instances.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd1[k] = rf[ad1[k]];
      rd2[k] = rf[ad2[k]];
    end
  end

  operand_fetch #(.A_BASE(5'd0), .B_BASE(5'd16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .rf_addr_1(ad1[0]), .rf_addr_2(ad1[1]), .rf_addr_3(ad1[2]), .rf_addr_4(ad1[3]),
    .rf_data_1(rd1[0]), .rf_data_2(rd1[1]), .rf_data_3(rd1[2]), .rf_data_4(rd1[3]),
    .op_valid(valid1), .op_ready(op_ready),
    .op_a0(op1[0]), .op_a1(op1[1]), .op_b0(op1[2]), .op_b1(op1[3]),
    .op_row(row1), .op_col(col1), .op_half(half1), .op_last(last1));

  operand_fetch #(.A_BASE(5'd20), .B_BASE(5'd0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
    .rf_addr_1(ad2[0]), .rf_addr_2(ad2[1]), .rf_addr_3(ad2[2]), .rf_addr_4(ad2[3]),
    .rf_data_1(rd2[0]), .rf_data_2(rd2[1]), .rf_data_3(rd2[2]), .rf_data_4(rd2[3]),
    .op_valid(valid2), .op_ready(op_ready),
    .op_a0(op2[0]), .op_a1(op2[1]), .op_b0(op2[2]), .op_b1(op2[3]),
    .op_row(row2), .op_col(col2), .op_half(half2), .op_last(last2));

  // Beat m covers i=m/8, j=(m%8)/2, h=m%2 with k0=2h, k1=2h+1.
  function automatic addr4_t exp_addr(input int ab, input int bb, input int m);
    int i, j, h;
    addr4_t r;
    i = m / 8;
    j = (m % 8) / 2;
    h = m % 2;
    r[0] = 5'((ab + 4 * i + 2 * h) % 32);
    r[1] = 5'((ab + 4 * i + 2 * h + 1) % 32);
`ifdef OPERAND_FETCH_TRANSPOSE_B_EN
    r[2] = 5'((bb + 4 * j + 2 * h) % 32);
    r[3] = 5'((bb + 4 * j + 2 * h + 1) % 32);
`else
    r[2] = 5'((bb + 4 * (2 * h) + j) % 32);
    r[3] = 5'((bb + 4 * (2 * h + 1) + j) % 32);
`endif
    return r;
  endfunction

  function automatic data4_t exp_data(input int ab, input int bb, input int m);
    addr4_t a;
    data4_t r;
    a = exp_addr(ab, bb, m);
    for (int k = 0; k < 4; k++) r[k] = rf[a[k]];
    return r;
  endfunction

  function automatic logic [5:0] exp_tag(input int m);
    int i, j, h;
    i = m / 8;
    j = (m % 8) / 2;
    h = m % 2;
    return {i[1:0], j[1:0], h[0], (m == 31)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_ctl1", 64'({busy1, done1, valid1, last1, half1, row1, col1}), 64'd0);
    chk("rst_ctl2", 64'({busy2, done2, valid2, last2, half2, row2, col2}), 64'd0);
    chk("rst_op1", 64'(op1), 64'd0);
    chk("rst_op2", 64'(op2), 64'd0);
    chk("rst_addr1", 64'(ad1), 64'(exp_addr(A1, B1, 0)));
    chk("rst_addr2", 64'(ad2), 64'(exp_addr(A2, B2, 0)));
  endtask

  // mode 0: ready held high, 1: ready toggling 1,0,1,0, 2: random ready.
  task automatic run(input int mode, input int mid_start_at, input int rst_at);
    int beat, n, stalls;
    logic seen_done, pulsed;
    beat = 0; stalls = 0; seen_done = 1'b0; pulsed = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'({busy1, busy2}), 64'd3);
    n = 0;
    while (!seen_done && n < 400) begin
      if (rst_at >= 0 && beat == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("no_done_after_rst", 64'({done1, done2, busy1, busy2}), 64'd0);
        end
        return;
      end
      if (done1) begin
        seen_done = 1'b1;
        chk("done_cycle", 64'(n), 64'(33 + stalls));
        chk("beats_at_done", 64'(beat), 64'd32);
        chk("done_state", 64'({done2, busy1, busy2, valid1, valid2}), 64'b10000);
      end else begin
        chk("busy_run", 64'({busy1, busy2, done2}), 64'b110);
        chk("valid_level", 64'({valid1, valid2}), (n >= 1) ? 64'd3 : 64'd0);
        chk("addr1", 64'(ad1), 64'(exp_addr(A1, B1, (beat + ((n >= 1) ? 1 : 0)) % 32)));
        chk("addr2", 64'(ad2), 64'(exp_addr(A2, B2, (beat + ((n >= 1) ? 1 : 0)) % 32)));
        if (n >= 1) begin
          chk("beat_data1", 64'(op1), 64'(exp_data(A1, B1, beat)));
          chk("beat_data2", 64'(op2), 64'(exp_data(A2, B2, beat)));
          chk("beat_tag1", 64'({row1, col1, half1, last1}), 64'(exp_tag(beat)));
          chk("beat_tag2", 64'({row2, col2, half2, last2}), 64'(exp_tag(beat)));
          if (ident && beat == 0) chk("beat0_const", 64'(op1), 64'({8'd20, 8'd16, 8'd1, 8'd0}));
          if (ident && beat == 31) chk("beat31_wrap_a", 64'({op2[1], op2[0]}), 64'({8'd3, 8'd2}));
`ifdef OPERAND_FETCH_TRANSPOSE_B_EN
          if (ident && beat == 1) chk("beat1_transposed", 64'(op1), 64'({8'd19, 8'd18, 8'd3, 8'd2}));
`else
          if (ident && beat == 31) chk("beat31_const", 64'(op1), 64'({8'd31, 8'd27, 8'd15, 8'd14}));
`endif
        end
        case (mode)
          0: op_ready = 1'b1;
          1: op_ready = (n % 2 == 0);
          default: op_ready = 1'($urandom_range(0, 1));
        endcase
        if (n >= 1 && op_ready) beat++;
        else if (n >= 1) stalls++;
        start = 1'b0;
        if (mid_start_at >= 0 && beat == mid_start_at && !pulsed) begin
          start = 1'b1;
          pulsed = 1'b1;
        end
        n++;
        @(negedge clk);
      end
    end
    if (!seen_done) chk("done_timeout", 64'd0, 64'd1);
    op_ready = 1'b1;
    @(negedge clk);
    chk("post_done_idle", 64'({done1, busy1, done2, busy2}), 64'd0);
    @(negedge clk);
    chk("start_not_queued", 64'({busy1, busy2, valid1}), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op_ready = 1'b0;
    ident = 1'b1;
    for (int a = 0; a < 32; a++) rf[a] = 8'(a);
    #12;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset();
    run(0, -1, -1);
    run(1, -1, -1);
    run(0, 10, -1);
    run(0, -1, 6);
    run(0, -1, -1);
    ident = 1'b0;
    for (int a = 0; a < 32; a++) rf[a] = 8'($urandom_range(0, 255));
    run(2, -1, -1);
    run(2, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
